dmem_ws: RTL and testbench

- Parametrised successor to the single-cycle data memory: word-organised RAM with configurable access latency (wait states) and a req/ready/rvalid handshake.
- Performs RV32I sized loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with sign/zero extension and byte-lane writes.
- Reports misaligned or illegal accesses through an err flag.
- Sits between the core's load/store path and data storage; lets the core be stalled by slower memory.

---
 rtl/dmem_ws.sv | 100 ++++++++++
 tb/tb_dmem_ws.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ws.sv
// dmem_ws: word-organised data RAM with wait states, req/ready/rvalid handshake and RV32I sized access faults
module dmem_ws #(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter int ADDR_W    = 32,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 2 ? $clog2(LATENCY - 1) : 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [2:0]      size_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];
  logic            accept, access, cur_we, fault;
  logic [AW+1:0]   cur_addr;
  logic [2:0]      cur_size;
  logic [31:0]     cur_wdata;
  logic [1:0]      lane;
  logic [AW-1:0]   idx;
  logic [31:0]     word, load_data, store_data;
  logic [15:0]     shifted;
  logic [3:0]      be;
  if (ADDR_W > AW + 2) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^addr[ADDR_W-1:AW+2];
  end
  assign ready     = state == IDLE;
  assign accept    = req && ready;
  assign access    = state == WAIT ? cnt == '0 : accept && LATENCY == 1;
  assign cur_we    = state == WAIT ? we_q : we;
  assign cur_addr  = state == WAIT ? addr_q : addr[AW+1:0];
  assign cur_size  = state == WAIT ? size_q : size;
  assign cur_wdata = state == WAIT ? wdata_q : wdata;
  assign lane      = cur_addr[1:0];
  assign idx       = cur_addr[AW+1:2];
  assign fault = cur_size == 3'b000 ? 1'b0 :
                 cur_size == 3'b001 ? lane[0] :
                 cur_size == 3'b010 ? |lane :
                 cur_size == 3'b100 ? cur_we :
                 cur_size == 3'b101 ? cur_we || lane[0] : 1'b1;
  assign word       = mem[idx];
  assign shifted    = 16'(word >> {lane, 3'b000});
  assign load_data  = cur_size[1] ? word :
                      cur_size[0] ? {{16{shifted[15] & ~cur_size[2]}}, shifted} :
                                    {{24{shifted[7] & ~cur_size[2]}}, shifted[7:0]};
  assign store_data = cur_wdata << {lane, 3'b000};
  assign be         = (cur_size[1] ? 4'b1111 : cur_size[0] ? 4'b0011 : 4'b0001) << lane;
  always_comb begin
    state_nx = state == IDLE && accept && LATENCY > 1 ? WAIT :
               state == WAIT && cnt == '0 ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt     <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
        we_q    <= we;
        addr_q  <= addr[AW+1:0];
        size_q  <= size;
        wdata_q <= wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      rvalid <= access;
      err    <= access && fault;
      rdata  <= access && !cur_we && !fault ? load_data : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (access && cur_we && !fault)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= store_data[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: four dmem_ws instances (LATENCY 2,4,1,3) checked every cycle
// against a byte-addressed behavioural model, plus hand-computed literal pins.
module tb_dmem_ws;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_a[4], we_a[4], ready_a[4], rvalid_a[4], err_a[4];
    logic [31:0] addr_a[4], wdata_a[4], rdata_a[4];
    logic [2:0]  size_a[4];

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
        int          due;
    } txn_t;

    txn_t        q[4][$];
    logic [7:0]  mem_m[4][4096];
    int          busy_until[4] = '{-1, -1, -1, -1};
    logic [31:0] last_rdata[4];
    logic        last_err[4];
    int          last_resp[4], last_e0[4];

    function automatic int lat(int k);
        return k == 0 ? 2 : k == 1 ? 4 : k == 2 ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_ws #(.DEPTH(1024), .LATENCY(g == 0 ? 2 : g == 1 ? 4 : g == 2 ? 1 : 3), .ADDR_W(32)) u_dut (
            .clk(clk), .rst_n(rst_n), .req(req_a[g]), .we(we_a[g]), .addr(addr_a[g]),
            .size(size_a[g]), .wdata(wdata_a[g]), .ready(ready_a[g]), .rvalid(rvalid_a[g]),
            .rdata(rdata_a[g]), .err(err_a[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut=%0d cyc=%0d got=%h expected=%h", nm, k, cyc, got, exp);
        end
    endtask

    // Byte-granular model: memory is 4096 bytes per instance (DEPTH*4 alias window)
    function automatic void model_exec(int k, txn_t t, output logic [31:0] r, output logic e);
        int nb;
        int base;
        bit legal;
        nb = t.s == 3'd2 ? 4 : (t.s == 3'd1 || t.s == 3'd5) ? 2 : 1;
        base = int'(t.a % 4096);
        legal = (t.s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(t.w && t.s > 3'd2) && (t.a % nb == 0);
        r = '0;
        e = !legal;
        if (legal && t.w) begin
            for (int i = 0; i < nb; i++) mem_m[k][base+i] = t.d[8*i +: 8];
        end else if (legal) begin
            for (int i = 0; i < nb; i++) r = r | (32'(mem_m[k][base+i]) << (8*i));
            if (t.s < 3'd4 && nb < 4 && r[8*nb-1]) r = r | (32'hFFFF_FFFF << (8*nb));
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] er;
                logic ee, ev;
                er = '0;
                ee = 1'b0;
                ev = 1'b0;
                if (q[k].size() > 0 && q[k][0].due == cyc) begin
                    model_exec(k, q[k][0], er, ee);
                    ev = 1'b1;
                    void'(q[k].pop_front());
                end
                chk("rvalid", k, 32'(rvalid_a[k]), 32'(ev));
                chk("rdata", k, rdata_a[k], er);
                chk("err", k, 32'(err_a[k]), 32'(ee));
                chk("ready", k, 32'(ready_a[k]), 32'(cyc > busy_until[k]));
                if (rvalid_a[k]) begin
                    last_rdata[k] = rdata_a[k];
                    last_err[k] = err_a[k];
                    last_resp[k] = cyc;
                end
            end
        end
    end

    task automatic issue(int k, bit w, logic [31:0] a, logic [2:0] s, logic [31:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        req_a[k] = 1'b1;
        we_a[k] = w;
        addr_a[k] = a;
        size_a[k] = s;
        wdata_a[k] = d;
        while (!acc && n < 20) begin
            acc = ready_a[k];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout dut=%0d got=no_accept expected=accept", k);
        end else begin
            last_e0[k] = cyc;
            busy_until[k] = cyc + lat(k) - 2;
            q[k].push_back('{w, a, s, d, cyc + lat(k) - 1});
        end
    endtask

    task automatic drain(int k);
        int n;
        n = 0;
        req_a[k] = 1'b0;
        while (q[k].size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q[k].size() != 0) begin
            checks++;
            fails++;
            $display("FAIL response_timeout dut=%0d got=pending expected=done", k);
            q[k].delete();
        end
    endtask

    task automatic xact(int k, bit w, logic [31:0] a, logic [2:0] s, logic [31:0] d);
        issue(k, w, a, s, d);
        drain(k);
    endtask

    initial begin
        int e1;
        int n;
        int k;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 1'b0;
            we_a[i] = 1'b0;
            addr_a[i] = '0;
            size_a[i] = '0;
            wdata_a[i] = '0;
        end
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_ready", i, 32'(ready_a[i]), 32'd1);
            chk("rst_rvalid", i, 32'(rvalid_a[i]), 32'd0);
            chk("rst_rdata", i, rdata_a[i], 32'd0);
            chk("rst_err", i, 32'(err_a[i]), 32'd0);
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 32; w++) xact(i, 1'b1, 32'(w * 4), 3'd2, $urandom);

        xact(0, 1'b1, 32'h20, 3'd2, 32'hDEAD_BEEF);
        chk("sw_latency", 0, 32'(last_resp[0] - last_e0[0]), 32'd1);
        chk("sw_err", 0, 32'(last_err[0]), 32'd0);
        xact(0, 1'b0, 32'h20, 3'd2, 32'h0);
        chk("lw", 0, last_rdata[0], 32'hDEAD_BEEF);
        chk("lw_latency", 0, 32'(last_resp[0] - last_e0[0]), 32'd1);
        xact(0, 1'b0, 32'h21, 3'd0, 32'h0);
        chk("lb", 0, last_rdata[0], 32'hFFFF_FFBE);
        xact(0, 1'b0, 32'h21, 3'd4, 32'h0);
        chk("lbu", 0, last_rdata[0], 32'h0000_00BE);
        xact(0, 1'b0, 32'h22, 3'd1, 32'h0);
        chk("lh", 0, last_rdata[0], 32'hFFFF_DEAD);
        xact(0, 1'b0, 32'h22, 3'd5, 32'h0);
        chk("lhu", 0, last_rdata[0], 32'h0000_DEAD);
        xact(0, 1'b1, 32'h23, 3'd0, 32'h11);
        xact(0, 1'b0, 32'h20, 3'd2, 32'h0);
        chk("sb_lw", 0, last_rdata[0], 32'h11AD_BEEF);
        xact(0, 1'b0, 32'h1020, 3'd2, 32'h0);
        chk("alias", 0, last_rdata[0], 32'h11AD_BEEF);
        xact(0, 1'b0, 32'h22, 3'd2, 32'h0);
        chk("lw_mis_err", 0, 32'(last_err[0]), 32'd1);
        chk("lw_mis_rdata", 0, last_rdata[0], 32'd0);
        xact(0, 1'b1, 32'h21, 3'd1, 32'hFFFF);
        chk("sh_mis_err", 0, 32'(last_err[0]), 32'd1);
        xact(0, 1'b0, 32'h20, 3'd2, 32'h0);
        chk("sh_mis_nowrite", 0, last_rdata[0], 32'h11AD_BEEF);
        xact(0, 1'b0, 32'h20, 3'd3, 32'h0);
        chk("size011_err", 0, 32'(last_err[0]), 32'd1);

        xact(1, 1'b1, 32'h40, 3'd2, 32'hA5A5_0F0F);
        issue(1, 1'b1, 32'h40, 3'd2, 32'h1234_5678);
        req_a[1] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 1, 32'(ready_a[1]), 32'd1);
        chk("async_rst_rvalid", 1, 32'(rvalid_a[1]), 32'd0);
        chk("async_rst_rdata", 1, rdata_a[1], 32'd0);
        chk("async_rst_err", 1, 32'(err_a[1]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            busy_until[i] = -1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        xact(1, 1'b0, 32'h40, 3'd2, 32'h0);
        chk("rst_abort_keep", 1, last_rdata[1], 32'hA5A5_0F0F);

        issue(3, 1'b0, 32'h4, 3'd2, 32'h0);
        e1 = last_e0[3];
        issue(3, 1'b0, 32'h8, 3'd2, 32'h0);
        chk("l3_gap", 3, 32'(last_e0[3] - e1), 32'd3);
        drain(3);

        issue(2, 1'b0, 32'h0, 3'd2, 32'h0);
        for (int i = 1; i < 4; i++) begin
            e1 = last_e0[2];
            issue(2, 1'b0, 32'(i * 4), 3'd2, 32'h0);
            chk("l1_b2b_gap", 2, 32'(last_e0[2] - e1), 32'd1);
        end
        drain(2);

        repeat (200) begin
            k = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 3));
            repeat (n) begin
                a = 32'($urandom_range(0, 127)) | ($urandom << 12);
                if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
                issue(k, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
            end
            drain(k);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
